// File: rtl/gfx_mem_arbiter.sv
// ==== gfx_mem_arbiter: shares one read-only memory port among four gfx fetch clients ====
// Rev 1.0
`default_nettype none

module gfx_mem_arbiter #(
  parameter int BITS           = 16,
  parameter int ADDRESS_BITS   = 16,
  parameter int PRIORITY_MODE  = 0,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic [ADDRESS_BITS-1:0] spcon_memory_address_i,
  input  logic                    spcon_rvalid_i,
  output logic                    spcon_rready_o,
  output logic [BITS-1:0]         spcon_memory_data_o,
  input  logic [ADDRESS_BITS-1:0] bg0_memory_address_i,
  input  logic                    bg0_rvalid_i,
  output logic                    bg0_rready_o,
  output logic [BITS-1:0]         bg0_memory_data_o,
  input  logic [ADDRESS_BITS-1:0] bg1_memory_address_i,
  input  logic                    bg1_rvalid_i,
  output logic                    bg1_rready_o,
  output logic [BITS-1:0]         bg1_memory_data_o,
  input  logic [ADDRESS_BITS-1:0] ov_memory_address_i,
  input  logic                    ov_rvalid_i,
  output logic                    ov_rready_o,
  output logic [BITS-1:0]         ov_memory_data_o,
  output logic [ADDRESS_BITS-1:0] mem_address_o,
  output logic                    mem_rvalid_o,
  input  logic                    mem_rready_i,
  input  logic [BITS-1:0]         mem_data_i,
  output logic                    busy_o,
  output logic                    timeout_err_o
);

  localparam int WDOG_BITS = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [WDOG_BITS-1:0] WDOG_LAST =
      (TIMEOUT_CYCLES > 0) ? WDOG_BITS'(TIMEOUT_CYCLES - 1) : '0;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MEM  = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e                  state_q;
  logic [1:0]              rr_ptr_q;
  logic [1:0]              gnt_q;
  logic [ADDRESS_BITS-1:0] mem_address_q;
  logic                    mem_rvalid_q;
  logic [3:0]              rready_q;
  logic [BITS-1:0]         data_q;
  logic                    busy_q;
  logic                    timeout_err_q;
  logic [WDOG_BITS-1:0]    wdog_q;
  logic [WDOG_BITS-1:0]    wdog_d;

  logic [3:0]              req;
  logic [3:0]              exclude;
  logic [3:0]              req_masked;
  logic                    arb_found;
  logic [1:0]              arb_idx;
  logic [1:0]              cand;
  logic [ADDRESS_BITS-1:0] addr_sel;
  logic                    timeout_hit;

  // In DONE the just-served client still shows rvalid, so it is masked out.
  always_comb begin
    req        = {ov_rvalid_i, bg1_rvalid_i, bg0_rvalid_i, spcon_rvalid_i};
    exclude    = (state_q == DONE) ? (4'b0001 << gnt_q) : 4'b0000;
    req_masked = req & ~exclude;
    arb_found  = |req_masked;
    arb_idx    = 2'd0;
    cand       = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      cand = (PRIORITY_MODE != 0) ? 2'(i) : rr_ptr_q + 2'(i);
      if (req_masked[cand]) arb_idx = cand;
    end
  end

  always_comb begin
    case (arb_idx)
      2'd0:    addr_sel = spcon_memory_address_i;
      2'd1:    addr_sel = bg0_memory_address_i;
      2'd2:    addr_sel = bg1_memory_address_i;
      default: addr_sel = ov_memory_address_i;
    endcase
  end

  assign wdog_d      = wdog_q + WDOG_BITS'(1);
  assign timeout_hit = (TIMEOUT_CYCLES != 0) && (wdog_q == WDOG_LAST);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q       <= IDLE;
      rr_ptr_q      <= 2'd0;
      gnt_q         <= 2'd0;
      mem_address_q <= '0;
      mem_rvalid_q  <= 1'b0;
      rready_q      <= 4'b0000;
      data_q        <= '0;
      busy_q        <= 1'b0;
      timeout_err_q <= 1'b0;
      wdog_q        <= '0;
    end else begin
      rready_q <= 4'b0000;
      case (state_q)
        IDLE, DONE: begin
          if (arb_found) begin
            state_q       <= MEM;
            gnt_q         <= arb_idx;
            mem_address_q <= addr_sel;
            mem_rvalid_q  <= 1'b1;
            busy_q        <= 1'b1;
            wdog_q        <= '0;
            if (PRIORITY_MODE == 0) rr_ptr_q <= arb_idx + 2'd1;
          end else begin
            state_q      <= IDLE;
            mem_rvalid_q <= 1'b0;
            busy_q       <= 1'b0;
          end
        end
        MEM: begin
          if (mem_rready_i || timeout_hit) begin
            state_q      <= DONE;
            mem_rvalid_q <= 1'b0;
            rready_q     <= 4'b0001 << gnt_q;
            if (mem_rready_i) begin
              data_q <= mem_data_i;
            end else begin
              data_q        <= '0;
              timeout_err_q <= 1'b1;
            end
          end else begin
            wdog_q <= wdog_d;
          end
        end
        default: begin
          state_q      <= IDLE;
          mem_rvalid_q <= 1'b0;
          busy_q       <= 1'b0;
        end
      endcase
    end
  end

  assign spcon_rready_o      = rready_q[0];
  assign bg0_rready_o        = rready_q[1];
  assign bg1_rready_o        = rready_q[2];
  assign ov_rready_o         = rready_q[3];
  assign spcon_memory_data_o = data_q;
  assign bg0_memory_data_o   = data_q;
  assign bg1_memory_data_o   = data_q;
  assign ov_memory_data_o    = data_q;
  assign mem_address_o       = mem_address_q;
  assign mem_rvalid_o        = mem_rvalid_q;
  assign busy_o              = busy_q;
  assign timeout_err_o       = timeout_err_q;

endmodule

`default_nettype wire

// File: tb/tb_gfx_mem_arbiter.sv
// ==== tb_gfx_mem_arbiter: table-driven bench for gfx_mem_arbiter (round-robin and fixed-priority) ====
// Rev 1.0
`default_nettype none

module tb_gfx_mem_arbiter;

  localparam logic [15:0] A_SP = 16'h1234, A_B0 = 16'h2000, A_B1 = 16'h3000, A_OV = 16'h4000;
  localparam logic [15:0] D_SP = 16'hBEEF, D_B0 = 16'hCCBB, D_B1 = 16'hDCBB, D_OV = 16'hECBB;

  logic       clk   = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] rv    = 4'b0000;
  logic       rr_en = 1'b1;
  logic       fp_en = 1'b1;
  int         n_chk  = 0;
  int         n_fail = 0;

  logic        rr_r0, rr_r1, rr_r2, rr_r3, rr_mrv, rr_mrdy, rr_busy, rr_terr;
  logic [15:0] rr_d0, rr_d1, rr_d2, rr_d3, rr_maddr, rr_mdata;
  logic        fp_r0, fp_r1, fp_r2, fp_r3, fp_mrv, fp_mrdy, fp_busy, fp_terr;
  logic [15:0] fp_d0, fp_d1, fp_d2, fp_d3, fp_maddr, fp_mdata;

  always #5 clk = ~clk;

  gfx_mem_arbiter #(.BITS(16), .ADDRESS_BITS(16), .PRIORITY_MODE(0), .TIMEOUT_CYCLES(4)) u_rr (
    .clk_i(clk), .rst_ni(rst_n),
    .spcon_memory_address_i(A_SP), .spcon_rvalid_i(rv[0]), .spcon_rready_o(rr_r0), .spcon_memory_data_o(rr_d0),
    .bg0_memory_address_i(A_B0),   .bg0_rvalid_i(rv[1]),   .bg0_rready_o(rr_r1),   .bg0_memory_data_o(rr_d1),
    .bg1_memory_address_i(A_B1),   .bg1_rvalid_i(rv[2]),   .bg1_rready_o(rr_r2),   .bg1_memory_data_o(rr_d2),
    .ov_memory_address_i(A_OV),    .ov_rvalid_i(rv[3]),    .ov_rready_o(rr_r3),    .ov_memory_data_o(rr_d3),
    .mem_address_o(rr_maddr), .mem_rvalid_o(rr_mrv), .mem_rready_i(rr_mrdy), .mem_data_i(rr_mdata),
    .busy_o(rr_busy), .timeout_err_o(rr_terr)
  );

  gfx_mem_arbiter #(.BITS(16), .ADDRESS_BITS(16), .PRIORITY_MODE(1), .TIMEOUT_CYCLES(0)) u_fp (
    .clk_i(clk), .rst_ni(rst_n),
    .spcon_memory_address_i(A_SP), .spcon_rvalid_i(rv[0]), .spcon_rready_o(fp_r0), .spcon_memory_data_o(fp_d0),
    .bg0_memory_address_i(A_B0),   .bg0_rvalid_i(rv[1]),   .bg0_rready_o(fp_r1),   .bg0_memory_data_o(fp_d1),
    .bg1_memory_address_i(A_B1),   .bg1_rvalid_i(rv[2]),   .bg1_rready_o(fp_r2),   .bg1_memory_data_o(fp_d2),
    .ov_memory_address_i(A_OV),    .ov_rvalid_i(rv[3]),    .ov_rready_o(fp_r3),    .ov_memory_data_o(fp_d3),
    .mem_address_o(fp_maddr), .mem_rvalid_o(fp_mrv), .mem_rready_i(fp_mrdy), .mem_data_i(fp_mdata),
    .busy_o(fp_busy), .timeout_err_o(fp_terr)
  );

  // Memory models: answer one cycle after mem_rvalid is seen, data = address + 16'hACBB.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_mrdy <= 1'b0; rr_mdata <= 16'h0;
      fp_mrdy <= 1'b0; fp_mdata <= 16'h0;
    end else begin
      rr_mrdy  <= rr_en && rr_mrv && !rr_mrdy;
      rr_mdata <= rr_maddr + 16'hACBB;
      fp_mrdy  <= fp_en && fp_mrv && !fp_mrdy;
      fp_mdata <= fp_maddr + 16'hACBB;
    end
  end

  typedef struct {
    bit          fp;
    logic [3:0]  rv;
    logic [3:0]  rdy;
    logic        mrv;
    logic        busy;
    logic        terr;
    logic [15:0] addr;
    logic [15:0] data;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(bit fp, logic [3:0] rvv, logic [3:0] rdy, logic mrv, logic busy,
                              logic terr, logic [15:0] addr, logic [15:0] data);
    vec_t v;
    v.fp = fp; v.rv = rvv; v.rdy = rdy; v.mrv = mrv; v.busy = busy;
    v.terr = terr; v.addr = addr; v.data = data;
    vecs.push_back(v);
  endfunction

  function automatic logic [15:0] addr_of(int c);
    case (c)
      0: return A_SP;
      1: return A_B0;
      2: return A_B1;
      default: return A_OV;
    endcase
  endfunction

  function automatic logic [15:0] data_of(int c);
    case (c)
      0: return D_SP;
      1: return D_B0;
      2: return D_B1;
      default: return D_OV;
    endcase
  endfunction

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  task automatic run_seg(input string tag, input int lo, input int hi);
    vec_t        v;
    logic [3:0]  rdy;
    logic        mrv, busy, terr;
    logic [15:0] maddr;
    logic [15:0] dat [4];
    int          di;
    for (int i = lo; i < hi; i++) begin
      v  = vecs[i];
      rv = v.rv;
      @(negedge clk);
      if (v.fp) begin
        rdy = {fp_r3, fp_r2, fp_r1, fp_r0}; mrv = fp_mrv; busy = fp_busy; terr = fp_terr;
        maddr = fp_maddr; dat[0] = fp_d0; dat[1] = fp_d1; dat[2] = fp_d2; dat[3] = fp_d3;
      end else begin
        rdy = {rr_r3, rr_r2, rr_r1, rr_r0}; mrv = rr_mrv; busy = rr_busy; terr = rr_terr;
        maddr = rr_maddr; dat[0] = rr_d0; dat[1] = rr_d1; dat[2] = rr_d2; dat[3] = rr_d3;
      end
      check($sformatf("%s[%0d].rready", tag, i - lo), 32'(rdy), 32'(v.rdy));
      check($sformatf("%s[%0d].mem_rvalid", tag, i - lo), 32'(mrv), 32'(v.mrv));
      check($sformatf("%s[%0d].busy", tag, i - lo), 32'(busy), 32'(v.busy));
      check($sformatf("%s[%0d].timeout_err", tag, i - lo), 32'(terr), 32'(v.terr));
      if (v.mrv) check($sformatf("%s[%0d].mem_address", tag, i - lo), 32'(maddr), 32'(v.addr));
      if (v.rdy != 4'b0000) begin
        di = 0;
        for (int k = 0; k < 4; k++) if (v.rdy[k]) di = k;
        check($sformatf("%s[%0d].data", tag, i - lo), 32'(dat[di]), 32'(v.data));
      end
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    rv    = 4'b0000;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  int s1, s2, s3, s4a, s4b, s5, s6;

  initial begin
    // Test 1: single spcon request, 1-cycle memory.
    s1 = vecs.size();
    add(0, 4'b0001, 4'b0000, 1, 1, 0, A_SP, 16'h0);
    add(0, 4'b0001, 4'b0000, 1, 1, 0, A_SP, 16'h0);
    add(0, 4'b0001, 4'b0001, 0, 1, 0, 16'h0, D_SP);
    add(0, 4'b0000, 4'b0000, 0, 0, 0, 16'h0, 16'h0);
    // Test 2: round-robin, all four requesting, 8 transactions.
    s2 = vecs.size();
    for (int t = 0; t < 8; t++) begin
      add(0, 4'b1111, 4'b0000, 1, 1, 0, addr_of(t % 4), 16'h0);
      add(0, 4'b1111, 4'b0000, 1, 1, 0, addr_of(t % 4), 16'h0);
      add(0, 4'b1111, 4'(4'b0001 << (t % 4)), 0, 1, 0, 16'h0, data_of(t % 4));
    end
    // Test 3: fixed priority, bg1+ov held, spcon pulsed mid-stream.
    s3 = vecs.size();
    add(1, 4'b1100, 4'b0000, 1, 1, 0, A_B1, 16'h0);
    add(1, 4'b1100, 4'b0000, 1, 1, 0, A_B1, 16'h0);
    add(1, 4'b1100, 4'b0100, 0, 1, 0, 16'h0, D_B1);
    add(1, 4'b1100, 4'b0000, 1, 1, 0, A_OV, 16'h0);
    add(1, 4'b1101, 4'b0000, 1, 1, 0, A_OV, 16'h0);
    add(1, 4'b1101, 4'b1000, 0, 1, 0, 16'h0, D_OV);
    add(1, 4'b1101, 4'b0000, 1, 1, 0, A_SP, 16'h0);
    add(1, 4'b1101, 4'b0000, 1, 1, 0, A_SP, 16'h0);
    add(1, 4'b1101, 4'b0001, 0, 1, 0, 16'h0, D_SP);
    add(1, 4'b1100, 4'b0000, 1, 1, 0, A_B1, 16'h0);
    add(1, 4'b1100, 4'b0000, 1, 1, 0, A_B1, 16'h0);
    add(1, 4'b1100, 4'b0100, 0, 1, 0, 16'h0, D_B1);
    add(1, 4'b0000, 4'b0000, 0, 0, 0, 16'h0, 16'h0);
    // Test 4a: a normal transaction so data_r is non-zero before the timeout.
    s4a = vecs.size();
    add(0, 4'b0001, 4'b0000, 1, 1, 0, A_SP, 16'h0);
    add(0, 4'b0001, 4'b0000, 1, 1, 0, A_SP, 16'h0);
    add(0, 4'b0001, 4'b0001, 0, 1, 0, 16'h0, D_SP);
    add(0, 4'b0000, 4'b0000, 0, 0, 0, 16'h0, 16'h0);
    // Test 4b: memory silent, watchdog fires after 4 MEM cycles.
    s4b = vecs.size();
    add(0, 4'b0010, 4'b0000, 1, 1, 0, A_B0, 16'h0);
    add(0, 4'b0010, 4'b0000, 1, 1, 0, A_B0, 16'h0);
    add(0, 4'b0010, 4'b0000, 1, 1, 0, A_B0, 16'h0);
    add(0, 4'b0010, 4'b0000, 1, 1, 0, A_B0, 16'h0);
    add(0, 4'b0010, 4'b0010, 0, 1, 1, 16'h0, 16'h0);
    add(0, 4'b0000, 4'b0000, 0, 0, 1, 16'h0, 16'h0);
    // Test 5: bg1 drops rvalid during MEM; its rready still pulses, nobody else's does.
    s5 = vecs.size();
    add(0, 4'b0100, 4'b0000, 1, 1, 1, A_B1, 16'h0);
    add(0, 4'b0000, 4'b0000, 1, 1, 1, A_B1, 16'h0);
    add(0, 4'b0000, 4'b0100, 0, 1, 1, 16'h0, D_B1);
    add(0, 4'b0000, 4'b0000, 0, 0, 1, 16'h0, 16'h0);
    s6 = vecs.size();

    repeat (2) @(negedge clk);
    check("reset.rr_mem_rvalid", 32'(rr_mrv), 32'd0);
    check("reset.rr_busy", 32'(rr_busy), 32'd0);
    check("reset.rr_timeout_err", 32'(rr_terr), 32'd0);
    check("reset.rr_rready", 32'({rr_r3, rr_r2, rr_r1, rr_r0}), 32'd0);
    check("reset.rr_mem_address", 32'(rr_maddr), 32'd0);
    check("reset.rr_data", 32'(rr_d0), 32'd0);
    check("reset.fp_mem_rvalid", 32'(fp_mrv), 32'd0);
    check("reset.fp_busy", 32'(fp_busy), 32'd0);
    check("reset.fp_rready", 32'({fp_r3, fp_r2, fp_r1, fp_r0}), 32'd0);
    rst_n = 1'b1;

    run_seg("t1", s1, s2);
    do_reset();
    run_seg("t2", s2, s3);
    do_reset();
    run_seg("t3", s3, s4a);
    do_reset();
    run_seg("t4a", s4a, s4b);
    rr_en = 1'b0;
    run_seg("t4b", s4b, s5);
    rr_en = 1'b1;
    run_seg("t5", s5, s6);

    // Test 6: rr_ptr is 3 here, so ov wins first; reset mid-MEM must restart at spcon.
    rv = 4'b1111;
    @(negedge clk);
    check("t6.pre_grant_addr", 32'(rr_maddr), 32'(A_OV));
    check("t6.pre_mem_rvalid", 32'(rr_mrv), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("t6.async_mem_rvalid", 32'(rr_mrv), 32'd0);
    check("t6.async_busy", 32'(rr_busy), 32'd0);
    check("t6.async_timeout_err", 32'(rr_terr), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("t6.grant_addr", 32'(rr_maddr), 32'(A_SP));
    check("t6.grant_mem_rvalid", 32'(rr_mrv), 32'd1);
    @(negedge clk);
    @(negedge clk);
    check("t6.rready", 32'({rr_r3, rr_r2, rr_r1, rr_r0}), 32'b0001);
    check("t6.data", 32'(rr_d0), 32'(D_SP));
    rv = 4'b0000;
    repeat (2) @(negedge clk);
    check("t6.idle_busy", 32'(rr_busy), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
